// File: rtl/game_sprite_motion_if.sv
// -----------------------------------------------------------------------------
// game_sprite_motion_if
//   Command/status bundle between the game master FSM and one sprite motion
//   engine.
//
//   master (game FSM / display side):
//     drives  sprite_write_xy, sprite_write_x, sprite_write_y,
//             sprite_write_dxy, sprite_write_dx, sprite_write_dy,
//             sprite_enable_update
//     samples sprite_x, sprite_y, sprite_within_screen, sprite_update_tick
//   slave (game_sprite_motion):
//     the mirror image of master
// -----------------------------------------------------------------------------
interface game_sprite_motion_if #(
  parameter int X_WIDTH   = 10,
  parameter int Y_WIDTH   = 10,
  parameter int DXY_WIDTH = 2
);

  logic                 sprite_write_xy;
  logic [X_WIDTH-1:0]   sprite_write_x;
  logic [Y_WIDTH-1:0]   sprite_write_y;
  logic                 sprite_write_dxy;
  logic [DXY_WIDTH-1:0] sprite_write_dx;
  logic [DXY_WIDTH-1:0] sprite_write_dy;
  logic                 sprite_enable_update;

  logic [X_WIDTH-1:0]   sprite_x;
  logic [Y_WIDTH-1:0]   sprite_y;
  logic                 sprite_within_screen;
  logic                 sprite_update_tick;

  modport master (
    output sprite_write_xy,
    output sprite_write_x,
    output sprite_write_y,
    output sprite_write_dxy,
    output sprite_write_dx,
    output sprite_write_dy,
    output sprite_enable_update,
    input  sprite_x,
    input  sprite_y,
    input  sprite_within_screen,
    input  sprite_update_tick
  );

  modport slave (
    input  sprite_write_xy,
    input  sprite_write_x,
    input  sprite_write_y,
    input  sprite_write_dxy,
    input  sprite_write_dx,
    input  sprite_write_dy,
    input  sprite_enable_update,
    output sprite_x,
    output sprite_y,
    output sprite_within_screen,
    output sprite_update_tick
  );

endinterface

// File: rtl/game_sprite_motion.sv
// -----------------------------------------------------------------------------
// game_sprite_motion
//   Position/velocity engine for one sprite (target or torpedo). While motion
//   is enabled, a prescaler counts UPDATE_PERIOD cycles and then steps x,y by
//   the signed dx,dy (modulo 2**WIDTH, no saturation). The FSM can load the
//   position and the velocity at any time; a position load beats a step and
//   restarts the prescaler.
//
// Ports
//   i_clk    in  system clock
//   i_reset  in  synchronous, active-high reset (priority over everything)
//   bus      game_sprite_motion_if.slave
//              in : sprite_write_xy/x/y, sprite_write_dxy/dx/dy,
//                   sprite_enable_update (level)
//              out: sprite_x, sprite_y (registered),
//                   sprite_within_screen (combinational from x,y),
//                   sprite_update_tick (1-cycle pulse aligned with new x,y)
// -----------------------------------------------------------------------------
module game_sprite_motion #(
  parameter int X_WIDTH       = 10,
  parameter int Y_WIDTH       = 10,
  parameter int DXY_WIDTH     = 2,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int SPRITE_WIDTH  = 8,
  parameter int SPRITE_HEIGHT = 8,
  parameter int UPDATE_PERIOD = 2**20
) (
  input logic                 i_clk,
  input logic                 i_reset,
  game_sprite_motion_if.slave bus
);

  localparam int                 PRE_W    = $clog2(UPDATE_PERIOD);
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(UPDATE_PERIOD - 1);
  localparam logic [PRE_W-1:0]   PRE_ONE  = PRE_W'(1);
  localparam logic [X_WIDTH-1:0] X_MAX    = X_WIDTH'(SCREEN_WIDTH - SPRITE_WIDTH);
  localparam logic [Y_WIDTH-1:0] Y_MAX    = Y_WIDTH'(SCREEN_HEIGHT - SPRITE_HEIGHT);

  logic [PRE_W-1:0]     r_prescale;
  logic [X_WIDTH-1:0]   r_x;
  logic [Y_WIDTH-1:0]   r_y;
  logic [DXY_WIDTH-1:0] r_dx;
  logic [DXY_WIDTH-1:0] r_dy;
  logic                 r_tick;

  logic                 w_step;
  logic                 w_prescale_clr;
  logic [X_WIDTH-1:0]   w_dx_ext;
  logic [Y_WIDTH-1:0]   w_dy_ext;

  // A step is due on the last enabled cycle of the period; a simultaneous
  // position load still wins, so the step only moves x,y when no load occurs.
  assign w_step         = bus.sprite_enable_update && (r_prescale == PRE_LAST);
  assign w_prescale_clr = !bus.sprite_enable_update || bus.sprite_write_xy || w_step;

  // Sign-extend the step so that adding it modulo 2**WIDTH moves backwards
  // for negative velocities (x=0, dx=-1 wraps to the maximum coordinate).
  assign w_dx_ext = {{(X_WIDTH-DXY_WIDTH){r_dx[DXY_WIDTH-1]}}, r_dx};
  assign w_dy_ext = {{(Y_WIDTH-DXY_WIDTH){r_dy[DXY_WIDTH-1]}}, r_dy};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prescale <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_tick     <= 1'b0;
    end else begin
      if (w_prescale_clr) begin
        r_prescale <= '0;
      end else begin
        r_prescale <= r_prescale + PRE_ONE;
      end

      if (bus.sprite_write_xy) begin
        r_x <= bus.sprite_write_x;
        r_y <= bus.sprite_write_y;
      end else if (w_step) begin
        r_x <= r_x + w_dx_ext;
        r_y <= r_y + w_dy_ext;
      end

      // The step above reads the old velocity; a new one applies next step.
      if (bus.sprite_write_dxy) begin
        r_dx <= bus.sprite_write_dx;
        r_dy <= bus.sprite_write_dy;
      end

      r_tick <= w_step && !bus.sprite_write_xy;
    end
  end

  assign bus.sprite_x             = r_x;
  assign bus.sprite_y             = r_y;
  assign bus.sprite_update_tick   = r_tick;
  // Unsigned compare: wrapped "negative" coordinates read as off-screen.
  assign bus.sprite_within_screen = (r_x <= X_MAX) && (r_y <= Y_MAX);

endmodule
